// File: rtl/sys_pkg.sv
// Shared definitions for the systolic sequencing counters.
// Mode encodings, default geometry and the half-adder cell.
package sys_pkg;

  localparam int SYS_WIDTH   = 6;
  localparam int SYS_LDSHIFT = 1;

  typedef enum logic [1:0] {
    SYS_CNT_WRAP    = 2'd0,
    SYS_CNT_ONESHOT = 2'd1,
    SYS_CNT_RELOAD  = 2'd2,
    SYS_CNT_RSVD    = 2'd3
  } sys_cnt_mode_e;

  typedef struct packed {
    logic s;
    logic c;
  } sys_ha_t;

  function automatic sys_ha_t sys_half_add(
    input logic a,
    input logic b
  );
    sys_ha_t r;
    r.s = a ^ b;
    r.c = a & b;
    return r;
  endfunction

endpackage

// File: rtl/sys_loop_counter_if.sv
// Control/status bundle between the loop sequencer and its counter.
// The master drives controls; the counter drives count/tc/done.
interface sys_loop_counter_if
  import sys_pkg::*;
#(
  parameter int WIDTH   = SYS_WIDTH,
  parameter int LDSHIFT = SYS_LDSHIFT
);

  logic                     cnten;
  logic                     cntld;
  logic [WIDTH-LDSHIFT-1:0] ldval;
  logic [WIDTH-1:0]         limit;
  logic [1:0]               mode;
  logic                     dir;
  logic [WIDTH-1:0]         count;
  logic                     tc;
  logic                     done;

  modport master (
    output cnten,
    output cntld,
    output ldval,
    output limit,
    output mode,
    output dir,
    input  count,
    input  tc,
    input  done
  );

  modport slave (
    input  cnten,
    input  cntld,
    input  ldval,
    input  limit,
    input  mode,
    input  dir,
    output count,
    output tc,
    output done
  );

endinterface

// File: rtl/sys_cnt_step.sv
// Combinational +/-1 step and terminal compare for the loop counter.
// Down counting reuses the incrementer: a-1 == ~(~a+1).
module sys_cnt_step
  import sys_pkg::*;
#(
  parameter int WIDTH = SYS_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  output logic [WIDTH-1:0] next,
  output logic             hit
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;

  assign x    = count ^ {WIDTH{dir}};
  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    sys_ha_t ha;
    assign ha   = sys_half_add(x[i], c[i]);
    assign s[i] = ha.s;
    if (i < WIDTH - 1) begin : g_c
      assign c[i+1] = ha.c;
    end
  end

  assign next = s ^ {WIDTH{dir}};
  assign hit  = &(~(count ^ limit));

endmodule

// File: rtl/sys_loop_counter.sv
// Loadable up/down loop counter with wrap, one-shot and reload modes.
// Paces the systolic multiply/accumulate loop.
module sys_loop_counter
  import sys_pkg::*;
#(
  parameter int WIDTH   = SYS_WIDTH,
  parameter int LDSHIFT = SYS_LDSHIFT
) (
  input logic              clk,
  input logic              resetl,
  sys_loop_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             done_q;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic             hit;

  sys_cnt_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .count(count_q),
    .limit(bus.limit),
    .dir  (bus.dir),
    .next (step_val),
    .hit  (hit)
  );

  assign load_val = WIDTH'(bus.ldval) << LDSHIFT;

  // Count value after a terminal step; reserved mode acts as wrap.
  always_comb begin
    term_val = step_val;
    unique case (1'b1)
      bus.mode == SYS_CNT_ONESHOT: term_val = count_q;
      bus.mode == SYS_CNT_RELOAD:  term_val = reload_q;
      default:                     term_val = step_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetl) begin
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.cntld) begin
      count_q  <= load_val;
      reload_q <= load_val;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.cnten && !done_q) begin
      tc_q <= hit;
      if (hit) begin
        count_q <= term_val;
        done_q  <= (bus.mode == SYS_CNT_ONESHOT);
      end else begin
        count_q <= step_val;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule
